if_fetch_unit: RTL and testbench

- Instruction-fetch stage between the 2Kx32 instruction RAM and the pipeline's decode input.
- Holds the word-addressed PC and issues one instruction-RAM read per cycle when it has queue credit. The RAM read is synchronous: data returns 1 cycle after the address.
- Captures returned words into a small prefetch FIFO and hands {instruction, PC} to decode over a valid/ready handshake.
- Honours branch redirects (flushes the FIFO and the in-flight read) and halt.

---
 rtl/if_fetch_unit_pkg.sv | 10 +
 rtl/if_fetch_unit_if.sv | 28 ++
 rtl/if_prefetch_fifo.sv | 45 ++++
 rtl/if_fetch_unit.sv | 62 ++++++
 tb/tb_if_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage constants and the {instr, pc} bundle handed to decode.
package if_fetch_unit_pkg;
    localparam int IM_ADDR_W = 11;
    localparam int IM_DATA_W = 32;

    typedef struct packed {
        logic [IM_DATA_W-1:0] instr;
        logic [IM_ADDR_W-1:0] pc;
    } fetch_bundle_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction-RAM read port, redirect/halt controls and the decode handshake.
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
);
    logic [ADDR_W-1:0] im_addr;
    logic              im_oen;
    logic [DATA_W-1:0] im_q;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_in;
    logic [DATA_W-1:0] ir_out;
    logic [ADDR_W-1:0] pc_out;
    logic              ir_valid;
    logic              ir_ready;

    modport master (
        output im_addr, im_oen, ir_out, pc_out, ir_valid,
        input  im_q, redirect, redirect_pc, halt_in, ir_ready
    );

    modport slave (
        input  im_addr, im_oen, ir_out, pc_out, ir_valid,
        output im_q, redirect, redirect_pc, halt_in, ir_ready
    );
endinterface

// File: rtl/if_prefetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries; flush empties it in one cycle.
module if_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 43
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Flush wins over push and pop: nothing from the old stream survives
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, credit-based RAM read issue, in-flight kill on redirect, prefetch FIFO to decode.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = IM_ADDR_W,
    parameter int                DATA_W   = IM_DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             rst_n,
    if_fetch_unit_if.master bus
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]  pc, inflight_pc;
    logic               inflight, issue, push, pop, full, empty;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credit_used;
    logic [ENTRY_W-1:0] head;

    // Credit counts queued words plus the read on the RAM bus, so a return always has room
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue = !rst_n && !bus.halt_in && !bus.redirect && (credit_used < (CNT_W+1)'(DEPTH));
    // A redirect kills the word returning this cycle
    assign push  = inflight && !bus.redirect;
    assign pop   = !empty && bus.ir_ready;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (bus.redirect)  pc <= bus.redirect_pc;
            else if (issue)    pc <= pc + ADDR_W'(1);
        end
    end

    if_prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .din   ({bus.im_q, inflight_pc}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.im_addr  = pc;
    assign bus.im_oen   = !issue;
    assign bus.ir_valid = !empty;
    assign {bus.ir_out, bus.pc_out} = head;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst_n) !(push && full));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model checked every cycle plus directed literal checks.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam int AW    = IM_ADDR_W;
    localparam int DW    = IM_DATA_W;
    localparam int DEPTH = 4;
    localparam int NPC   = 1 << AW;
    localparam int LOGN  = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    if_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(11'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] mem [NPC];
    initial for (int i = 0; i < NPC; i++) mem[i] = 32'h1000_0000 + i;

    // Synchronous-read RAM; garbage on the bus when not enabled
    always @(posedge clk) bus.im_q <= bus.im_oen ? DW'($urandom()) : mem[bus.im_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: the prefetch queue as a list of PCs, the outstanding read, the fetch PC
    int m_pc = 0;
    int m_q[$];
    bit m_infl = 0;
    int m_infl_pc = 0;
    bit chk_en = 0;

    function automatic bit m_issue();
        return !rst_n && !bus.halt_in && !bus.redirect && (m_q.size() + int'(m_infl) < DEPTH);
    endfunction

    always @(posedge clk) begin
        bit iss, popped;
        iss    = m_issue();
        popped = (m_q.size() > 0) && bus.ir_ready;
        if (rst_n) begin
            m_pc = 0; m_q.delete(); m_infl = 0; chk_en = 1;
        end else begin
            if (bus.redirect) m_q.delete();
            else begin
                if (popped) void'(m_q.pop_front());
                if (m_infl) m_q.push_back(m_infl_pc);
            end
            m_infl    = iss;
            m_infl_pc = m_pc;
            if (bus.redirect) m_pc = int'(bus.redirect_pc);
            else if (iss)     m_pc = (m_pc + 1) % NPC;
        end
    end

    logic          lg_valid [LOGN];
    logic          lg_oen   [LOGN];
    logic          lg_pop   [LOGN];
    logic [AW-1:0] lg_pc    [LOGN];
    logic [AW-1:0] lg_addr  [LOGN];
    logic [DW-1:0] lg_ir    [LOGN];

    always @(negedge clk) begin
        if (chk_en) begin
            check("im_oen",   bus.im_oen,   !m_issue());
            check("im_addr",  bus.im_addr,  64'(m_pc));
            check("ir_valid", bus.ir_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                check("pc_out", bus.pc_out, 64'(m_q[0]));
                check("ir_out", bus.ir_out, mem[m_q[0]]);
            end
        end
        if (cyc < LOGN) begin
            lg_valid[cyc] = bus.ir_valid;
            lg_oen[cyc]   = bus.im_oen;
            lg_pop[cyc]   = bus.ir_valid && bus.ir_ready;
            lg_pc[cyc]    = bus.pc_out;
            lg_addr[cyc]  = bus.im_addr;
            lg_ir[cyc]    = bus.ir_out;
        end
    end

    function automatic int nth_pop(int from, int n);
        int seen = 0;
        for (int c = from; c < from + 200 && c < LOGN; c++)
            if (lg_pop[c]) begin
                if (seen == n) return c;
                seen++;
            end
        return -1;
    endfunction

    task automatic check_pop(input string name, input int from, input int n, input int exp);
        int c;
        c = nth_pop(from, n);
        check(name, (c >= 0) ? 64'(lg_pc[c]) : 64'hFFFF, 64'(exp));
    endtask

    function automatic int issues_in(int from, int to);
        int k = 0;
        for (int c = from; c <= to; c++) if (!lg_oen[c]) k++;
        return k;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        bus.redirect = 1'b0;
        bus.halt_in  = 1'b0;
        tick(2);
        rst_n = 1'b0;
    endtask

    initial begin
        int c0, n, r;
        bus.ir_ready = 1'b1;
        bus.halt_in = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;

        // Reset state, then streaming at one instruction per cycle
        rst_n = 1'b1;
        tick(2);
        check("rst_valid", bus.ir_valid, 0);
        check("rst_oen",   bus.im_oen,   1);
        check("rst_addr",  bus.im_addr,  0);
        rst_n = 1'b0;
        c0 = cyc;
        tick(8);
        check("s_addr0", lg_addr[c0], 0);
        check("s_oen0",  lg_oen[c0],  0);
        check("s_addr1", lg_addr[c0+1], 1);
        check("s_addr2", lg_addr[c0+2], 2);
        check("s_valid1", lg_valid[c0+1], 0);
        check("s_ir2",   lg_ir[c0+2], 32'h1000_0000);
        for (int k = 0; k < 5; k++) begin
            check("s_vseq", lg_valid[c0+2+k], 1);
            check("s_pcseq", lg_pc[c0+2+k], 64'(k));
        end

        // Back-pressure: exactly DEPTH reads issued, then drains in order
        do_reset();
        c0 = cyc;
        bus.ir_ready = 1'b0;
        tick(10);
        check("bp_issues", issues_in(c0, c0 + 9), 4);
        check("bp_oen9",   lg_oen[c0+9], 1);
        check("bp_head",   lg_pc[c0+9],  0);
        bus.ir_ready = 1'b1;
        tick(12);
        for (int k = 0; k < 8; k++) check_pop("bp_drain", c0 + 10, k, k);

        // Redirect to 0x100 with 5..7 queued and 8 in flight
        do_reset();
        c0 = cyc;
        bus.ir_ready = 1'b0; tick(5);
        bus.ir_ready = 1'b1; tick(5);
        bus.ir_ready = 1'b0; tick(1);
        check("rd_model_q",  m_q.size(), 3);
        check("rd_model_h",  (m_q.size() > 0) ? m_q[0] : -1, 5);
        check("rd_model_if", m_infl ? m_infl_pc : -1, 8);
        bus.redirect = 1'b1;
        bus.redirect_pc = 11'h100;
        n = cyc;
        tick(1);
        bus.redirect = 1'b0;
        bus.ir_ready = 1'b1;
        tick(10);
        check("rd_v1", lg_valid[n+1], 0);
        check("rd_v2", lg_valid[n+2], 0);
        check("rd_v3", lg_valid[n+3], 1);
        check("rd_pc", lg_pc[n+3], 11'h100);
        check("rd_ir", lg_ir[n+3], 32'h1000_0100);
        check_pop("rd_seq0", c0, 0, 0);
        check_pop("rd_seq4", c0, 4, 4);
        check_pop("rd_seq5", c0, 5, 256);
        check_pop("rd_seq6", c0, 6, 257);

        // Redirect near the top of the address space: wrap to 0
        bus.redirect = 1'b1;
        bus.redirect_pc = 11'd2046;
        n = cyc;
        tick(1);
        bus.redirect = 1'b0;
        tick(10);
        check_pop("wrap0", n + 1, 0, 2046);
        check_pop("wrap1", n + 1, 1, 2047);
        check_pop("wrap2", n + 1, 2, 0);
        check_pop("wrap3", n + 1, 3, 1);

        // Halt with two queued and one in flight
        do_reset();
        c0 = cyc;
        tick(4);
        bus.ir_ready = 1'b0; tick(1);
        check("h_model_q",  m_q.size(), 2);
        check("h_model_if", m_infl, 1);
        bus.halt_in = 1'b1;
        bus.ir_ready = 1'b1;
        tick(8);
        n = 0;
        for (int c = c0 + 5; c < c0 + 13; c++) if (lg_pop[c]) n++;
        check("h_delivered", n, 3);
        check_pop("h_pop0", c0 + 5, 0, 2);
        check_pop("h_pop2", c0 + 5, 2, 4);
        check("h_issues", issues_in(c0 + 5, c0 + 12), 0);
        check("h_empty", lg_valid[c0+8], 0);
        bus.halt_in = 1'b0;
        tick(10);
        check_pop("h_resume", c0 + 13, 0, 5);
        check("h_resume_cyc", nth_pop(c0 + 13, 0), c0 + 15);

        // Reset mid-stream with three words queued
        do_reset();
        tick(4);
        bus.ir_ready = 1'b0; tick(2);
        check("r_model_q", m_q.size(), 3);
        rst_n = 1'b1;
        r = cyc;
        tick(1);
        rst_n = 1'b0;
        bus.ir_ready = 1'b1;
        tick(6);
        check("r_v1", lg_valid[r+1], 0);
        check("r_addr", lg_addr[r+1], 0);
        check("r_oen", lg_oen[r+1], 0);
        check("r_v2", lg_valid[r+2], 0);
        check("r_v3", lg_valid[r+3], 1);
        check("r_pc3", lg_pc[r+3], 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.ir_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) bus.halt_in = !bus.halt_in;
            bus.redirect = ($urandom_range(0, 24) == 0);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? AW'(2044 + $urandom_range(0, 3))
                                                          : AW'($urandom_range(0, NPC - 1));
            rst_n = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        bus.redirect = 1'b0;
        rst_n = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
